// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction-fetch stage feeding decode.
//
// Owns the program counter and issues word-aligned requests to instruction
// memory. In-order responses are buffered in a small FIFO and presented to
// decode as {instruction, PC}. A redirect from execute reloads the PC, flushes
// the FIFO and marks every request still in flight as stale, so that its
// response is discarded when it returns.
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_rst             synchronous active-low reset
//   o_imem_req_valid  request valid (credit-limited)
//   i_imem_req_ready  memory accepts the request this cycle
//   o_imem_addr       request address, always word-aligned
//   i_imem_rsp_valid  in-order response valid, never back-pressured
//   i_imem_rsp_data   fetched instruction word
//   i_redirect        load a new PC this cycle
//   i_redirect_pc     redirect target, low two bits forced to zero
//   o_inst_valid      FIFO head valid
//   i_inst_ready      decode consumes the head
//   o_inst            head instruction
//   o_inst_pc         PC of the head instruction
// -----------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_TOP = PW'(DEPTH - 1);

    logic [31:0]   pc_r;
    logic [31:0]   rsp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   inst_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];

    logic [CW:0]   inflight_s;
    logic          req_fire_s;
    logic          rsp_fire_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] outstanding_nxt_s;
    logic [31:0]   target_s;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_TOP) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Requests in flight plus buffered entries never exceed DEPTH, which is
    // what guarantees a response always finds a free FIFO slot.
    assign inflight_s        = {1'b0, outstanding_r} + {1'b0, count_r};
    assign o_imem_req_valid  = i_rst & (inflight_s < DEPTH_W);
    assign o_imem_addr       = pc_r;
    assign req_fire_s        = o_imem_req_valid & i_imem_req_ready;

    // A response with nothing outstanding is a protocol error; it is ignored
    // here so the counters cannot underflow, and flagged by the checker.
    assign rsp_fire_s        = i_rst & i_imem_rsp_valid & (outstanding_r != {CW{1'b0}});
    assign drop_s            = rsp_fire_s & ((drop_cnt_r != {CW{1'b0}}) | i_redirect);
    assign push_s            = rsp_fire_s & ~drop_s;

    assign o_inst_valid      = i_rst & (count_r != {CW{1'b0}});
    assign pop_s             = o_inst_valid & i_inst_ready;
    assign o_inst            = inst_mem_r[rd_ptr_r];
    assign o_inst_pc         = pc_mem_r[rd_ptr_r];

    assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(rsp_fire_s);
    assign target_s          = i_redirect_pc & 32'hFFFF_FFFC;

    // Control state: PC, response PC, credit counters and FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (i_redirect) begin
                // Everything still in flight after this edge is stale,
                // including a request accepted in this very cycle.
                pc_r       <= target_s;
                rsp_pc_r   <= target_s;
                drop_cnt_r <= outstanding_nxt_s;
                count_r    <= {CW{1'b0}};
                rd_ptr_r   <= {PW{1'b0}};
                wr_ptr_r   <= {PW{1'b0}};
            end else begin
                if (req_fire_s) begin
                    pc_r <= pc_r + 32'd4;
                end else begin
                    pc_r <= pc_r;
                end
                // Without a redirect, a drop only happens while drop_cnt > 0.
                if (drop_s) begin
                    drop_cnt_r <= drop_cnt_r - CW'(1);
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end else begin
                    rsp_pc_r <= rsp_pc_r;
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    // FIFO storage; contents are meaningless while the count is zero, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_redirect) begin
            inst_mem_r[wr_ptr_r] <= i_imem_rsp_data;
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
        end
    end

    fetch_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk         (i_clk),
        .rst         (i_rst),
        .rsp_valid   (i_imem_rsp_valid),
        .outstanding (outstanding_r),
        .count       (count_r),
        .addr_lsb    (pc_r[1:0])
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_checker -- simulation-time protocol and invariant checks for fetch.
//
// Ports
//   clk, rst     clock and active-low reset of the checked block
//   rsp_valid    memory response valid
//   outstanding  requests in flight
//   count        FIFO occupancy
//   addr_lsb     low bits of the request address
// -----------------------------------------------------------------------------
module fetch_checker #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] count,
    input logic [1:0]    addr_lsb
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_rsp_has_request : assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> (outstanding != {CW{1'b0}}));

    a_fifo_bounded : assert property (@(posedge clk) disable iff (!rst)
        count <= DEPTH_C);

    a_addr_aligned : assert property (@(posedge clk) disable iff (!rst)
        addr_lsb == 2'b00);

endmodule
